// File: rtl/uart_baud_gen_os.sv
// uart_baud_gen_os: oversampling baud-rate generator for the UART TX/RX paths.
// Divides clk by a runtime divisor into an oversample tick, then derives a
// bit-boundary TX strobe and a mid-bit RX sample strobe from the tick count.
// rx_sync re-aligns the phase on an RX start-bit edge.
//
// Optional build macro: UART_BAUD_FRAC_DIV_EN
//   Defined   -> FRAC_W-bit fractional accumulator stretches some periods by
//                one cycle, giving an average period of os_div + frac/2^FRAC_W.
//   Undefined -> integer divide only; frac is ignored.
//   The port list is the same in both builds.
//
// Ports:
//   clk            in   system clock
//   rst            in   asynchronous reset, active-high
//   en             in   generator enable; low clears the generator
//   os_div         in   clk cycles per oversample tick (0 treated as 1)
//   frac           in   fractional cycles per tick, units of 1/2^FRAC_W
//   rx_sync        in   pulse that restarts the bit phase (RX start edge)
//   os_tick        out  oversample strobe, one cycle wide
//   rx_sample_tick out  mid-bit sample strobe, one cycle wide
//   tx_bit_tick    out  bit-boundary strobe, one cycle wide
//   os_phase       out  current oversample phase, 0..OS_RATE-1

module uart_baud_gen_os #(
    parameter int DIV_W   = 16,
    parameter int OS_RATE = 16,
    parameter int FRAC_W  = 4,
    localparam int PH_W   = $clog2(OS_RATE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [DIV_W-1:0]  os_div,
    input  logic [FRAC_W-1:0] frac,
    input  logic              rx_sync,
    output logic              os_tick,
    output logic              rx_sample_tick,
    output logic              tx_bit_tick,
    output logic [PH_W-1:0]   os_phase
);

    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS_RATE - 1);
    localparam logic [PH_W-1:0] PH_MID  = PH_W'(OS_RATE / 2);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_eff;
    logic [PH_W-1:0]  phase;
    logic [PH_W-1:0]  phase_nxt;
    logic             tick_due;
    logic             clear;
    logic             carry;

    assign div_eff   = (os_div == '0) ? DIV_W'(1) : os_div;
    // >= rather than == so a divisor lowered below the running count
    // produces a tick on the very next edge instead of wrapping around.
    assign tick_due  = (cnt >= div_eff);
    assign clear     = !en || rx_sync;
    assign phase_nxt = (phase == PH_LAST) ? '0 : phase + PH_W'(1);
    assign os_phase  = phase;

`ifdef UART_BAUD_FRAC_DIV_EN
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, frac};
    assign carry   = acc_sum[FRAC_W];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (tick_due) begin
            acc <= acc_sum[FRAC_W-1:0];
        end
    end
`else
    logic unused_frac;

    assign carry       = 1'b0;
    assign unused_frac = ^frac;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt            <= '0;
            phase          <= '0;
            os_tick        <= 1'b0;
            rx_sample_tick <= 1'b0;
            tx_bit_tick    <= 1'b0;
        end else if (clear) begin
            // rx_sync wins over a tick due this cycle; that tick is dropped.
            cnt            <= '0;
            phase          <= '0;
            os_tick        <= 1'b0;
            rx_sample_tick <= 1'b0;
            tx_bit_tick    <= 1'b0;
        end else if (tick_due) begin
            // Reloading 0 instead of 1 adds the extra fractional cycle.
            cnt            <= carry ? '0 : DIV_W'(1);
            phase          <= phase_nxt;
            os_tick        <= 1'b1;
            rx_sample_tick <= (phase_nxt == PH_MID);
            tx_bit_tick    <= (phase_nxt == '0);
        end else begin
            cnt            <= cnt + DIV_W'(1);
            os_tick        <= 1'b0;
            rx_sample_tick <= 1'b0;
            tx_bit_tick    <= 1'b0;
        end
    end

endmodule
